// File: rtl/ysyx_25060173_mdu.sv
// ysyx_25060173_mdu: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// One operand bit per cycle; divide-by-zero and signed overflow bypass the iteration.
`default_nettype none

module ysyx_25060173_mdu #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_src1,
   input  logic [XLEN-1:0] in_src2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [2:0]        op;
   logic [2*XLEN-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
   logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
   logic [CNT_W-1:0]  cnt;
   logic              neg_main;  // negate product or quotient
   logic              neg_rem;

   logic              accept;
   logic              is_div;
   logic              sgn1;
   logic              sgn2;
   logic              signed1;
   logic              signed2;
   logic [XLEN-1:0]   abs1;
   logic [XLEN-1:0]   abs2;
   logic              div_zero;
   logic              div_ovf;
   logic              fast;

   assign accept   = (state == S_IDLE) && in_valid && !flush;
   assign is_div   = in_op[2];
   assign sgn1     = in_src1[XLEN-1];
   assign sgn2     = in_src2[XLEN-1];
   assign signed1  = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
   assign signed2  = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
   assign abs1     = (signed1 && sgn1) ? -in_src1 : in_src1;
   assign abs2     = (signed2 && sgn2) ? -in_src2 : in_src2;
   assign div_zero = is_div && (in_src2 == '0);
   assign div_ovf  = is_div && !in_op[0] && (in_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_src2);
   assign fast     = div_zero || div_ovf;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] div_next;

   assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
   assign mul_next  = {mul_sum, acc[XLEN-1:1]};
   assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opb};
   assign div_ge    = !div_diff[XLEN];
   assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   final_res;

   assign prod = neg_main ? -acc : acc;
   assign quot = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
   assign rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

   always_comb begin
      final_res = '0;
      case (op)
         3'd0:                final_res = prod[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    final_res = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:          final_res = quot;
         default:             final_res = rem;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) state_nxt = fast ? S_DONE : (is_div ? S_DIV : S_MUL);
         end
         S_MUL, S_DIV: begin
            if (flush)                 state_nxt = S_IDLE;
            else if (cnt == CNT_LAST)  state_nxt = S_DONE;
         end
         S_DONE: begin
            if (flush || (out_valid && out_ready)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == S_IDLE);
   end

   // DONE spends its first cycle applying the sign fix-up, then presents the result.
   always_ff @(posedge clock) begin
      if (reset) begin
         op         <= '0;
         acc        <= '0;
         opb        <= '0;
         cnt        <= '0;
         neg_main   <= 1'b0;
         neg_rem    <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               out_valid <= 1'b0;
               if (accept) begin
                  op  <= in_op;
                  cnt <= '0;
                  if (fast) begin
                     acc      <= div_zero ? {in_src1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, in_src1};
                     neg_main <= 1'b0;
                     neg_rem  <= 1'b0;
                  end else if (is_div) begin
                     acc      <= {{XLEN{1'b0}}, abs1};
                     opb      <= abs2;
                     neg_main <= !in_op[0] && (sgn1 ^ sgn2);
                     neg_rem  <= !in_op[0] && sgn1;
                  end else begin
                     acc      <= {{XLEN{1'b0}}, abs2};
                     opb      <= abs1;
                     neg_main <= (in_op == 3'd1) ? (sgn1 ^ sgn2) : ((in_op == 3'd2) && sgn1);
                     neg_rem  <= 1'b0;
                  end
               end
            end
            S_MUL: begin
               acc <= mul_next;
               cnt <= cnt + 1'b1;
            end
            S_DIV: begin
               acc <= div_next;
               cnt <= cnt + 1'b1;
            end
            default: begin
               if (flush) begin
                  out_valid <= 1'b0;
               end else if (!out_valid) begin
                  out_valid  <= 1'b1;
                  out_result <= final_res;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25060173_mdu.sv
// tb_ysyx_25060173_mdu: directed vectors for the MDU at XLEN=32 and XLEN=16.
`default_nettype none

module tb_ysyx_25060173_mdu;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [2:0]  in_op = 3'd0;
   logic [31:0] in_src1 = '0;
   logic [31:0] in_src2 = '0;
   bit          sel16 = 1'b0;

   logic        in_ready32, out_valid32;
   logic [31:0] out_result32;
   logic        in_ready16, out_valid16;
   logic [15:0] out_result16;

   logic        v32, v16, r32, r16;
   logic        obs_ready, obs_valid;
   logic [31:0] obs_result;

   assign v32 = in_valid && !sel16;
   assign v16 = in_valid && sel16;
   assign r32 = out_ready && !sel16;
   assign r16 = out_ready && sel16;
   assign obs_ready  = sel16 ? in_ready16 : in_ready32;
   assign obs_valid  = sel16 ? out_valid16 : out_valid32;
   assign obs_result = sel16 ? {16'h0, out_result16} : out_result32;

   ysyx_25060173_mdu #(.XLEN(32)) dut32 (
      .clock(clock), .reset(reset), .in_valid(v32), .in_ready(in_ready32),
      .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
      .out_valid(out_valid32), .out_ready(r32), .out_result(out_result32)
   );

   ysyx_25060173_mdu #(.XLEN(16)) dut16 (
      .clock(clock), .reset(reset), .in_valid(v16), .in_ready(in_ready16),
      .in_op(in_op), .in_src1(in_src1[15:0]), .in_src2(in_src2[15:0]), .flush(flush),
      .out_valid(out_valid16), .out_ready(r16), .out_result(out_result16)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, time it from the accept edge, check the result and the handoff.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int ready_seen;
      lat = 0;
      ready_seen = 0;
      @(negedge clock);
      in_op = op; in_src1 = a; in_src2 = b; in_valid = 1'b1;
      check({tag, "_rdy"}, obs_ready, 1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_op = ~op; in_src1 = $urandom; in_src2 = $urandom;
      while (!obs_valid && lat < 100) begin
         @(posedge clock); #1;
         lat++;
         if (obs_ready) ready_seen++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_res"}, obs_result, exp_res);
      check({tag, "_busy"}, ready_seen, 0);
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check({tag, "_ack"}, {obs_valid, obs_ready}, 2'b01);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      int cnt;
      repeat (3) @(posedge clock);
      #1;
      check("reset_state", {obs_ready, obs_valid, obs_result}, {1'b1, 1'b0, 32'h0});
      @(negedge clock);
      reset = 1'b0;

      run_op("mul",      3'd0, 32'd7,        32'd6,        32'd42,       33);
      run_op("mul_neg",  3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
      run_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("div",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu",     3'd5, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu",     3'd7, 32'd100,      32'd7,        32'd2,        33);
      run_op("div_z",    3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("remu_z",   3'd7, 32'd5,        32'd0,        32'd5,        1);
      run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

      // Backpressure: result must hold while in_valid pulses are ignored.
      @(negedge clock);
      in_op = 3'd5; in_src1 = 32'd100; in_src2 = 32'd7; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!obs_valid && cnt < 100) begin
         @(posedge clock); #1;
         cnt++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         in_valid = i[0]; in_op = 3'd0;
         @(posedge clock); #1;
         check("bp_hold", {obs_valid, obs_ready, obs_result}, {1'b1, 1'b0, 32'd14});
      end
      @(negedge clock);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      check("bp_release", {obs_valid, obs_ready}, 2'b01);
      cnt = 0;
      repeat (5) begin
         @(posedge clock); #1;
         if (obs_valid) cnt++;
      end
      check("bp_one_handoff", cnt, 0);

      // Flush ten cycles into a divide.
      @(negedge clock);
      in_op = 3'd4; in_src1 = 32'd100; in_src2 = 32'd7; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check("flush_idle", {obs_ready, obs_valid}, 2'b10);
      cnt = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (obs_valid) cnt++;
      end
      check("flush_no_result", cnt, 0);

      // Flush beats a simultaneous request in IDLE.
      @(negedge clock);
      in_op = 3'd5; in_src1 = 32'd9; in_src2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_wins", {obs_ready, obs_valid}, 2'b10);

      // Synchronous reset in the middle of a multiply.
      @(negedge clock);
      in_op = 3'd0; in_src1 = 32'd7; in_src2 = 32'd6; in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check("reset_mid_mul", {obs_ready, obs_valid, obs_result}, {1'b1, 1'b0, 32'h0});
      @(negedge clock);
      reset = 1'b0;
      run_op("divu_after", 3'd5, 32'd9, 32'd3, 32'd3, 33);

      @(negedge clock);
      sel16 = 1'b1;
      run_op("x16_mulh",    3'd1, 32'h8000, 32'h8000, 32'h4000, 17);
      run_op("x16_mul",     3'd0, 32'hFFFD, 32'd5,    32'hFFF1, 17);
      run_op("x16_divu",    3'd5, 32'd9,    32'd3,    32'd3,    17);
      run_op("x16_div",     3'd4, 32'hFFF9, 32'd2,    32'hFFFD, 17);
      run_op("x16_rem",     3'd6, 32'hFFF9, 32'd2,    32'hFFFF, 17);
      run_op("x16_div_ovf", 3'd4, 32'h8000, 32'hFFFF, 32'h8000, 1);
      run_op("x16_div_z",   3'd5, 32'd9,    32'd0,    32'hFFFF, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
